// File: rtl/me_full_search.sv
// Full-search block-matching motion estimator: streams one row pair per cycle from external RAMs,
// accumulates per-candidate SAD and keeps the earliest minimum, with optional early termination.
module me_full_search #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int PIX_W      = 8,
    parameter int RD_LAT     = 1,
    localparam int P     = SEARCH_DIM - MACRO_DIM + 1,
    localparam int LOG_M = $clog2(MACRO_DIM),
    localparam int SAD_W = PIX_W + 2 * LOG_M,
    localparam int PW    = (P > 1) ? $clog2(P) : 1,
    localparam int SA_W  = $clog2(SEARCH_DIM)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       early_en_i,
    input  logic [SAD_W-1:0]           sad_thresh_i,
    output logic [LOG_M-1:0]           cur_addr_o,
    output logic [SA_W-1:0]            srch_addr_o,
    output logic [PW-1:0]              srch_off_o,
    input  logic [MACRO_DIM*PIX_W-1:0] cur_row_i,
    input  logic [MACRO_DIM*PIX_W-1:0] srch_row_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [SAD_W-1:0]           min_sad_o,
    output logic [PW-1:0]              mv_x_o,
    output logic [PW-1:0]              mv_y_o,
    output logic                       early_o
);

    localparam int ROW_W = PIX_W + LOG_M;
    localparam int TAG_W = 2 + 2 * PW;
    localparam logic [LOG_M-1:0] LAST_ROW = LOG_M'(MACRO_DIM - 1);
    localparam logic [PW-1:0]    LAST_POS = PW'(P - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e state_q, state_d;

    logic issue, accept;

    logic [LOG_M-1:0] rowIdx_q;
    logic [PW-1:0]    cx_q, cy_q;
    logic             earlyEn_q;
    logic [SAD_W-1:0] thresh_q;

    logic [RD_LAT-1:0] pipeValid_q;
    logic [TAG_W-1:0]  pipeTag_q [RD_LAT];
    logic              rowValid_q;
    logic [TAG_W-1:0]  rowTag_q;
    logic [ROW_W-1:0]  rowSad_q;
    logic [SAD_W-1:0]  acc_q;

    logic [SAD_W-1:0] bestSad_q;
    logic [PW-1:0]    bestX_q, bestY_q;
    logic             early_q;

    logic             lastIssue;
    logic [TAG_W-1:0] issueTag;
    logic             dataValid;
    logic [TAG_W-1:0] dataTag;
    logic             rowFirst, rowLast;
    logic [PW-1:0]    rowCx, rowCy;
    logic [SAD_W-1:0] candSad;
    logic             candDone, earlyHit, better, pipeBusy;

    logic [PIX_W-1:0] absDiff [MACRO_DIM];
    logic [ROW_W-1:0] rowSadComb;

    // Per-column absolute difference between current and search pixels.
    for (genvar i = 0; i < MACRO_DIM; i++) begin : gCol
        logic [PIX_W-1:0] curPix, srchPix;
        assign curPix     = cur_row_i[i*PIX_W +: PIX_W];
        assign srchPix    = srch_row_i[i*PIX_W +: PIX_W];
        assign absDiff[i] = (curPix >= srchPix) ? (curPix - srchPix) : (srchPix - curPix);
    end

    always_comb begin
        rowSadComb = '0;
        for (int i = 0; i < MACRO_DIM; i++) begin
            rowSadComb = rowSadComb + ROW_W'(absDiff[i]);
        end
    end

    assign lastIssue = (rowIdx_q == LAST_ROW) && (cx_q == LAST_POS) && (cy_q == LAST_POS);
    assign issueTag  = {rowIdx_q == '0, rowIdx_q == LAST_ROW, cx_q, cy_q};
    assign dataValid = pipeValid_q[RD_LAT-1];
    assign dataTag   = pipeTag_q[RD_LAT-1];
    assign pipeBusy  = |pipeValid_q;

    assign rowFirst = rowTag_q[TAG_W-1];
    assign rowLast  = rowTag_q[TAG_W-2];
    assign rowCx    = rowTag_q[2*PW-1:PW];
    assign rowCy    = rowTag_q[PW-1:0];

    // The first row of a candidate restarts the sum instead of adding to the previous candidate.
    assign candSad  = (rowFirst ? '0 : acc_q) + SAD_W'(rowSad_q);
    assign candDone = rowValid_q && rowLast;
    assign earlyHit = candDone && earlyEn_q && (candSad <= thresh_q);
    assign better   = candDone && (candSad < bestSad_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (earlyHit || lastIssue) state_d = DRAIN;
            DRAIN:   if (earlyHit || !pipeBusy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
        issue   = (state_q == RUN);
        accept  = (state_q == IDLE) && start_i;
    end

    // Raster scan counters; they stop on the final issue or an early stop so the addresses hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rowIdx_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            earlyEn_q <= 1'b0;
            thresh_q  <= '0;
        end else if (accept) begin
            rowIdx_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            earlyEn_q <= early_en_i;
            thresh_q  <= sad_thresh_i;
        end else if (issue && !lastIssue && !earlyHit) begin
            if (rowIdx_q == LAST_ROW) begin
                rowIdx_q <= '0;
                if (cx_q == LAST_POS) begin
                    cx_q <= '0;
                    cy_q <= cy_q + PW'(1);
                end else begin
                    cx_q <= cx_q + PW'(1);
                end
            end else begin
                rowIdx_q <= rowIdx_q + LOG_M'(1);
            end
        end
    end

    assign cur_addr_o  = rowIdx_q;
    assign srch_addr_o = SA_W'(cy_q) + SA_W'(rowIdx_q);
    assign srch_off_o  = cx_q;

    // Tags travel alongside the RAM latency; an early stop flushes everything still in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipeValid_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipeTag_q[k] <= '0;
            end
            rowValid_q <= 1'b0;
            rowTag_q   <= '0;
            rowSad_q   <= '0;
            acc_q      <= '0;
        end else begin
            pipeValid_q[0] <= issue && !earlyHit;
            pipeTag_q[0]   <= issueTag;
            for (int k = 1; k < RD_LAT; k++) begin
                pipeValid_q[k] <= pipeValid_q[k-1] && !earlyHit;
                pipeTag_q[k]   <= pipeTag_q[k-1];
            end
            rowValid_q <= dataValid && !earlyHit;
            if (dataValid) begin
                rowTag_q <= dataTag;
                rowSad_q <= rowSadComb;
            end
            if (rowValid_q) begin
                acc_q <= candSad;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bestSad_q <= '0;
            bestX_q   <= '0;
            bestY_q   <= '0;
            early_q   <= 1'b0;
        end else if (accept) begin
            bestSad_q <= '1;
            bestX_q   <= '0;
            bestY_q   <= '0;
            early_q   <= 1'b0;
        end else if (earlyHit) begin
            bestSad_q <= candSad;
            bestX_q   <= rowCx;
            bestY_q   <= rowCy;
            early_q   <= 1'b1;
        end else if (better) begin
            bestSad_q <= candSad;
            bestX_q   <= rowCx;
            bestY_q   <= rowCy;
        end
    end

    assign min_sad_o = bestSad_q;
    assign mv_x_o    = bestX_q;
    assign mv_y_o    = bestY_q;
    assign early_o   = early_q;

endmodule

// File: tb/tb_me_full_search.sv
// Scoreboard bench for me_full_search: three instances (4/8/lat1, 4/8/lat3, defaults) fed by
// behavioural RAM models; expected results are queued at start and checked when valid strobes.
module tb_me_full_search;

    typedef struct {
        int dut;
        int sad;
        int mx;
        int my;
        int early;
        int startCnt;
        int minLat;
        int maxLat;
    } exp_t;

    logic clk;
    logic rst;
    logic earlyEn;
    logic [15:0] thresh;
    int cycCount = 0;
    int testsRun = 0;
    int testsFailed = 0;
    exp_t expQ[$];

    logic [7:0] curMem [0:255];
    logic [7:0] winMem [0:2303];

    logic startA, readyA, validA, earlyA;
    logic [1:0] curAddrA;
    logic [2:0] srchAddrA, srchOffA, mvXA, mvYA;
    logic [31:0] curRowA, srchRowA;
    logic [11:0] minSadA;

    logic startB, readyB, validB, earlyB;
    logic [1:0] curAddrB;
    logic [2:0] srchAddrB, srchOffB, mvXB, mvYB;
    logic [31:0] curRowB, srchRowB, b1Cur, b1Srch, b2Cur, b2Srch;
    logic [11:0] minSadB;

    logic startC, readyC, validC, earlyC;
    logic [3:0] curAddrC;
    logic [5:0] srchAddrC, srchOffC, mvXC, mvYC;
    logic [127:0] curRowC, srchRowC;
    logic [15:0] minSadC;

    me_full_search #(.MACRO_DIM(4), .SEARCH_DIM(8), .PIX_W(8), .RD_LAT(1)) dutA (
        .clk_i(clk), .rst_i(rst), .start_i(startA), .early_en_i(earlyEn),
        .sad_thresh_i(thresh[11:0]), .cur_addr_o(curAddrA), .srch_addr_o(srchAddrA),
        .srch_off_o(srchOffA), .cur_row_i(curRowA), .srch_row_i(srchRowA),
        .ready_o(readyA), .valid_o(validA), .min_sad_o(minSadA),
        .mv_x_o(mvXA), .mv_y_o(mvYA), .early_o(earlyA)
    );

    me_full_search #(.MACRO_DIM(4), .SEARCH_DIM(8), .PIX_W(8), .RD_LAT(3)) dutB (
        .clk_i(clk), .rst_i(rst), .start_i(startB), .early_en_i(earlyEn),
        .sad_thresh_i(thresh[11:0]), .cur_addr_o(curAddrB), .srch_addr_o(srchAddrB),
        .srch_off_o(srchOffB), .cur_row_i(curRowB), .srch_row_i(srchRowB),
        .ready_o(readyB), .valid_o(validB), .min_sad_o(minSadB),
        .mv_x_o(mvXB), .mv_y_o(mvYB), .early_o(earlyB)
    );

    me_full_search dutC (
        .clk_i(clk), .rst_i(rst), .start_i(startC), .early_en_i(earlyEn),
        .sad_thresh_i(thresh), .cur_addr_o(curAddrC), .srch_addr_o(srchAddrC),
        .srch_off_o(srchOffC), .cur_row_i(curRowC), .srch_row_i(srchRowC),
        .ready_o(readyC), .valid_o(validC), .min_sad_o(minSadC),
        .mv_x_o(mvXC), .mv_y_o(mvYC), .early_o(earlyC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    // Behavioural RAMs: row r of the block, and MACRO_DIM window pixels from (srch_off, srch_addr).
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            curRowA[i*8 +: 8]  <= curMem[int'(curAddrA) * 4 + i];
            srchRowA[i*8 +: 8] <= winMem[int'(srchAddrA) * 8 + int'(srchOffA) + i];
            b1Cur[i*8 +: 8]    <= curMem[int'(curAddrB) * 4 + i];
            b1Srch[i*8 +: 8]   <= winMem[int'(srchAddrB) * 8 + int'(srchOffB) + i];
        end
        b2Cur    <= b1Cur;
        b2Srch   <= b1Srch;
        curRowB  <= b2Cur;
        srchRowB <= b2Srch;
        for (int i = 0; i < 16; i++) begin
            curRowC[i*8 +: 8]  <= curMem[int'(curAddrC) * 16 + i];
            srchRowC[i*8 +: 8] <= winMem[int'(srchAddrC) * 48 + int'(srchOffC) + i];
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input longint act, input longint lo, input longint hi);
        testsRun++;
        if (act < lo || act > hi) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every valid strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        int nv;
        int who;
        int aSad, aX, aY, aE;
        exp_t e;
        nv = int'(validA) + int'(validB) + int'(validC);
        if (nv > 0) begin
            if (validA) begin
                who = 0; aSad = int'(minSadA); aX = int'(mvXA); aY = int'(mvYA); aE = int'(earlyA);
            end else if (validB) begin
                who = 1; aSad = int'(minSadB); aX = int'(mvXB); aY = int'(mvYB); aE = int'(earlyB);
            end else begin
                who = 2; aSad = int'(minSadC); aX = int'(mvXC); aY = int'(mvYC); aE = int'(earlyC);
            end
            if (nv > 1) checkOutput("single valid strobe", nv, 1);
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected valid: dut %0d strobed with no search pending", who);
            end else begin
                e = expQ.pop_front();
                checkOutput("result dut id", who, e.dut);
                checkOutput("min_sad", aSad, e.sad);
                checkOutput("mv_x", aX, e.mx);
                checkOutput("mv_y", aY, e.my);
                checkOutput("early", aE, e.early);
                checkRange("valid latency", cycCount - e.startCnt, e.minLat, e.maxLat);
            end
        end
    end

    task automatic fillConst(input int curVal, input int winVal);
        for (int i = 0; i < 256; i++) curMem[i] = 8'(curVal);
        for (int i = 0; i < 2304; i++) winMem[i] = 8'(winVal);
    endtask

    // Block pixel (r,c) = r*16+c+1, pasted into an otherwise 0xFF window at (px,py).
    task automatic fillMatch(input int m, input int s, input int px, input int py);
        fillConst(0, 255);
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < m; c++) begin
                curMem[r*m + c]             = 8'(r*16 + c + 1);
                winMem[(py + r)*s + px + c] = 8'(r*16 + c + 1);
            end
        end
    endtask

    task automatic applyStimulus(input int dut, input logic en, input int th, input bit pushExp,
                                 input int eSad, input int eX, input int eY, input int eEarly,
                                 input int minLat, input int maxLat);
        exp_t e;
        @(posedge clk); #1;
        earlyEn = en;
        thresh  = 16'(th);
        case (dut)
            0:       startA = 1'b1;
            1:       startB = 1'b1;
            default: startC = 1'b1;
        endcase
        if (pushExp) begin
            e.dut = dut; e.sad = eSad; e.mx = eX; e.my = eY; e.early = eEarly;
            e.startCnt = cycCount; e.minLat = minLat; e.maxLat = maxLat;
            expQ.push_back(e);
        end
        @(posedge clk); #1;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        earlyEn = 1'b0; thresh = '0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: no result within %0d cycles", name, budget);
            expQ.delete();
        end
    endtask

    initial begin
        rst = 1'b1; startA = 1'b0; startB = 1'b0; startC = 1'b0;
        earlyEn = 1'b0; thresh = '0;
        fillConst(0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", readyA, 1);
        checkOutput("reset valid", validA, 0);
        checkOutput("reset min_sad", minSadA, 0);
        checkOutput("reset mv_x", mvXA, 0);
        checkOutput("reset early", earlyA, 0);
        checkOutput("reset srch_addr", srchAddrA, 0);
        checkOutput("reset min_sad default", minSadC, 0);
        rst = 1'b0;

        // Exact match at (3,2), full search.
        fillMatch(4, 8, 3, 2);
        applyStimulus(0, 1'b0, 0, 1'b1, 0, 3, 2, 0, 103, 103);
        checkOutput("issue1 cur_addr", curAddrA, 0);
        checkOutput("issue1 srch_addr", srchAddrA, 0);
        checkOutput("issue1 srch_off", srchOffA, 0);
        @(posedge clk); #1;
        checkOutput("issue2 cur_addr", curAddrA, 1);
        checkOutput("issue2 srch_addr", srchAddrA, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("issue5 cur_addr", curAddrA, 0);
        checkOutput("issue5 srch_off", srchOffA, 1);
        waitDone("match search", 300);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold min_sad", minSadA, 0);
        checkOutput("hold mv_x", mvXA, 3);
        checkOutput("hold mv_y", mvYA, 2);
        checkOutput("idle ready", readyA, 1);
        checkOutput("valid one cycle", validA, 0);
        checkOutput("hold cur_addr", curAddrA, 3);
        checkOutput("hold srch_addr", srchAddrA, 7);
        checkOutput("hold srch_off", srchOffA, 4);

        // Flat image: every candidate ties at zero, earliest wins.
        fillConst(16, 16);
        applyStimulus(0, 1'b0, 0, 1'b1, 0, 0, 0, 0, 103, 103);
        waitDone("tie search", 300);

        // Early stop at the exact match.
        fillMatch(4, 8, 3, 2);
        applyStimulus(0, 1'b1, 0, 1'b1, 0, 3, 2, 1, 58, 70);
        waitDone("early match", 300);

        // Threshold equal to the first candidate's SAD (3304) stops on candidate (0,0).
        fillMatch(4, 8, 3, 2);
        applyStimulus(0, 1'b1, 3304, 1'b1, 3304, 0, 0, 1, 6, 12);
        waitDone("early threshold equal", 300);

        // Same match search with three-cycle RAM latency.
        fillMatch(4, 8, 3, 2);
        applyStimulus(1, 1'b0, 0, 1'b1, 0, 3, 2, 0, 105, 105);
        waitDone("latency 3 search", 300);

        // A second start during RUN must not restart or re-arm early stop.
        fillMatch(4, 8, 3, 2);
        applyStimulus(0, 1'b0, 0, 1'b1, 0, 3, 2, 0, 103, 103);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("ready during run", readyA, 0);
        earlyEn = 1'b1; thresh = 16'd4095; startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0; earlyEn = 1'b0; thresh = '0;
        waitDone("start ignored", 300);

        // Reset mid-search: outputs clear immediately and no result appears.
        applyStimulus(0, 1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort ready", readyA, 1);
        checkOutput("abort valid", validA, 0);
        checkOutput("abort min_sad", minSadA, 0);
        checkOutput("abort mv_x", mvXA, 0);
        checkOutput("abort mv_y", mvYA, 0);
        checkOutput("abort early", earlyA, 0);
        checkOutput("abort cur_addr", curAddrA, 0);
        checkOutput("abort srch_off", srchOffA, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (150) @(posedge clk);
        applyStimulus(0, 1'b0, 0, 1'b1, 0, 3, 2, 0, 103, 103);
        waitDone("fresh after abort", 300);

        // Default geometry, worst-case SAD everywhere.
        fillConst(0, 255);
        applyStimulus(2, 1'b0, 0, 1'b1, 65280, 0, 0, 0, 17427, 17427);
        waitDone("default worst case", 18000);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
